de_adpcm: RTL and testbench

Decoder for the pair-wise delta stream produced by the upstream ADPCM-style encoder; it sits directly downstream of that encoder on the receive side. Input arrives as alternating words: a raw 16-bit {CbCr, Y} sample, then a delta-coded word referenced to that raw sample. The block re-expands each coded word against the preceding raw word and emits a continuous 16-bit sample stream with a fixed 2-cycle latency. It also keeps a completed-pair count and sticky/pulse error flags for link monitoring.

---
 rtl/de_adpcm.sv | 101 ++++++++++
 tb/tb_de_adpcm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/de_adpcm.sv
// Receive-side decoder for the pair-wise ADPCM delta stream: raw {CbCr,Y} word,
// then a sign/magnitude coded word, re-expanded through a fixed 2-stage pipeline.
module de_adpcm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [15:0] din,
  output logic        out_en,
  output logic [15:0] dout,
  output logic [15:0] pair_cnt,
  output logic        fmt_err,
  output logic        orphan
);

  // Stage-1 state: input phase tracker and the registered word.
  logic        ph_q;
  logic        s1_en_q;
  logic        s1_ph_q;
  logic [15:0] s1_din_q;

  // Stage-2 state: reference raw word and registered outputs.
  logic [15:0] prev_q,     prev_d;
  logic        out_en_q;
  logic [15:0] dout_q,     dout_d;
  logic [15:0] pair_cnt_q, pair_cnt_d;
  logic        fmt_err_q,  fmt_err_d;
  logic        orphan_q,   orphan_d;

  // Reconstruct one byte: magnitude m maps to (m*135)>>2, applied with saturation.
  function automatic logic [7:0] dec_byte(input logic [7:0] p,
                                          input logic       sgn,
                                          input logic [2:0] m);
    logic [9:0] r;
    logic [9:0] s;
    r = ({7'd0, m} * 10'd135) >> 2;
    if (sgn) begin
      s = {2'b00, p} + r;
      dec_byte = (s > 10'd255) ? 8'hFF : s[7:0];
    end else begin
      s = {2'b00, p} - r;
      dec_byte = s[9] ? 8'h00 : s[7:0];
    end
  endfunction

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    prev_d     = prev_q;
    dout_d     = 16'h0000;
    pair_cnt_d = pair_cnt_q;
    fmt_err_d  = fmt_err_q;
    orphan_d   = 1'b0;
    if (s1_en_q) begin
      if (!s1_ph_q) begin
        prev_d   = s1_din_q;
        dout_d   = s1_din_q;
        // A raw word followed by an idle input cycle will never get its coded word.
        orphan_d = ~in_en;
      end else begin
        dout_d     = {dec_byte(prev_q[15:8], s1_din_q[11], s1_din_q[10:8]),
                      dec_byte(prev_q[7:0],  s1_din_q[3],  s1_din_q[2:0])};
        pair_cnt_d = pair_cnt_q + 16'd1;
        if ((|s1_din_q[15:12]) || (|s1_din_q[7:4])) fmt_err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q       <= 1'b0;
      s1_en_q    <= 1'b0;
      s1_ph_q    <= 1'b0;
      s1_din_q   <= 16'h0000;
      prev_q     <= 16'h0000;
      out_en_q   <= 1'b0;
      dout_q     <= 16'h0000;
      pair_cnt_q <= 16'h0000;
      fmt_err_q  <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      ph_q       <= in_en ? ~ph_q : 1'b0;
      s1_en_q    <= in_en;
      s1_ph_q    <= in_en & ph_q;
      s1_din_q   <= din;
      prev_q     <= prev_d;
      out_en_q   <= s1_en_q;
      dout_q     <= dout_d;
      pair_cnt_q <= pair_cnt_d;
      fmt_err_q  <= fmt_err_d;
      orphan_q   <= orphan_d;
    end
  end

  assign out_en   = out_en_q;
  assign dout     = dout_q;
  assign pair_cnt = pair_cnt_q;
  assign fmt_err  = fmt_err_q;
  assign orphan   = orphan_q;

endmodule

// File: tb/tb_de_adpcm.sv
// Scoreboard bench for de_adpcm: stimulus pushes model predictions, an
// independent monitor pops and compares whenever out_en is presented.
module tb_de_adpcm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en;
  logic [15:0] din;
  logic        out_en;
  logic [15:0] dout;
  logic [15:0] pair_cnt;
  logic        fmt_err;
  logic        orphan;

  de_adpcm dut (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .din      (din),
    .out_en   (out_en),
    .dout     (dout),
    .pair_cnt (pair_cnt),
    .fmt_err  (fmt_err),
    .orphan   (orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [15:0] dout;
    logic        orphan;
    logic [15:0] cnt;
    logic        fmt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] burst[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model state.
  logic [15:0] model_prev = 16'h0000;
  logic [15:0] model_cnt  = 16'h0000;
  logic        model_fmt  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte reconstruction straight from the arithmetic definition, clamped to 0..255.
  function automatic logic [7:0] ref_byte(input int p, input bit up, input int m);
    int r;
    int v;
    r = (m * 135) / 4;
    v = up ? p + r : p - r;
    if (v > 255) v = 255;
    if (v < 0)   v = 0;
    return v[7:0];
  endfunction

  // Drives the words in 'burst' on consecutive cycles, then one idle cycle.
  task automatic drive_burst();
    exp_t e;
    for (int i = 0; i < burst.size(); i++) begin
      @(posedge clk); #1;
      in_en = 1'b1;
      din   = burst[i];
      if (i % 2 == 0) begin
        model_prev = burst[i];
        e.dout     = burst[i];
        e.orphan   = (i == burst.size() - 1);
      end else begin
        e.dout = {ref_byte(int'(model_prev[15:8]), burst[i][11], int'(burst[i][10:8])),
                  ref_byte(int'(model_prev[7:0]),  burst[i][3],  int'(burst[i][2:0]))};
        e.orphan  = 1'b0;
        model_cnt = model_cnt + 16'd1;
        if ((burst[i] & 16'hF0F0) != 16'h0000) model_fmt = 1'b1;
      end
      e.cnt = model_cnt;
      e.fmt = model_fmt;
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_en = 1'b0;
    din   = 16'($urandom);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    sb.delete();
    model_cnt = 16'h0000;
    model_fmt = 1'b0;
    #1;
    check("rst_out_en",   out_en,   0);
    check("rst_dout",     dout,     0);
    check("rst_pair_cnt", pair_cnt, 0);
    check("rst_fmt_err",  fmt_err,  0);
    check("rst_orphan",   orphan,   0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: independent of stimulus, compares at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (out_en) begin
        if (sb.size() == 0) begin
          check("spurious_out_en", out_en, 0);
        end else begin
          mon_e = sb.pop_front();
          check("latency",  cyc,      mon_e.cyc);
          check("dout",     dout,     mon_e.dout);
          check("orphan",   orphan,   mon_e.orphan);
          check("pair_cnt", pair_cnt, mon_e.cnt);
          check("fmt_err",  fmt_err,  mon_e.fmt);
        end
      end else begin
        check("idle_dout",   dout,   0);
        check("idle_orphan", orphan, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_en = 1'b0;
    din   = 16'h0000;
    #2;
    apply_reset();

    // Basic pair, saturation, reserved bits with a clean pair after.
    burst = '{16'h8040, 16'h0A01};  drive_burst();
    burst = '{16'hF005, 16'h0F07};  drive_burst();
    burst = '{16'h1010, 16'h1000};  drive_burst();
    burst = '{16'h5555, 16'h0303};  drive_burst();
    // Orphan raw word, then a burst that must restart at phase 0.
    burst = '{16'h1234};            drive_burst();
    burst = '{16'h2020, 16'h0801};  drive_burst();
    repeat (4) @(posedge clk);

    // Reset while a raw word is on the output and its coded word is in flight.
    @(posedge clk); #1; in_en = 1'b1; din = 16'h4466;
    @(posedge clk); #1; din = 16'h7A0B;
    @(posedge clk); #1; in_en = 1'b0;
    #1;
    apply_reset();
    burst = '{16'h9090, 16'h0909};  drive_burst();

    // Randomized bursts with random gaps; coded words are mostly clean.
    for (int b = 0; b < 250; b++) begin
      int len;
      logic [15:0] w;
      len = $urandom_range(1, 6);
      burst.delete();
      for (int i = 0; i < len; i++) begin
        w = 16'($urandom);
        if (i % 2 == 1 && $urandom_range(0, 15) != 0) w = w & 16'h0F0F;
        burst.push_back(w);
      end
      drive_burst();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      if (b == 120) begin
        @(posedge clk); #3;
        apply_reset();
      end
    end

    // Counter wrap: preload the count just below the top, then run two pairs.
    repeat (4) @(posedge clk);
    #1;
    force dut.pair_cnt_d = 16'hFFFE;
    @(posedge clk); #1;
    release dut.pair_cnt_d;
    model_cnt = 16'hFFFE;
    burst = '{16'h0102, 16'h0000, 16'h0304, 16'h0808};  drive_burst();

    repeat (5) @(posedge clk);
    #1;
    check("wrap_pair_cnt", pair_cnt, 0);
    check("queue_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
